ones_comp_checksum: RTL and testbench

ONES_COMP_CHECKSUM -- requirements
Module: ones_comp_checksum

---
 rtl/ones_comp_pkg.sv | 16 +
 rtl/oc_add_eac.sv | 26 ++
 rtl/ones_comp_checksum.sv | 127 ++++++++++++
 tb/tb_ones_comp_checksum.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_comp_pkg.sv
// ----------------------------------------------------------------------------
// ones_comp_pkg
// Shared definitions for the ones'-complement checksum block:
//   - default operand width and word-counter width
//   - FSM state encodings (IDLE, ACCUM, HOLD)
// ----------------------------------------------------------------------------
package ones_comp_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage : ones_comp_pkg

// File: rtl/oc_add_eac.sv
// ----------------------------------------------------------------------------
// oc_add_eac
// W-bit ones'-complement adder: the carry out of the plain sum is folded
// back into bit 0 (end-around carry).
// Ports:
//   a_i   [W-1:0]  first operand
//   b_i   [W-1:0]  second operand
//   sum_o [W-1:0]  ones'-complement sum
// ----------------------------------------------------------------------------
module oc_add_eac #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i};

  // Folding the carry back in cannot overflow again: the largest raw sum is
  // 2^(W+1)-2, whose low part plus one is at most all-ones.
  assign sum_o = raw_sum[W-1:0] + {{(W-1){1'b0}}, raw_sum[W]};

endmodule : oc_add_eac

// File: rtl/ones_comp_checksum.sv
// ----------------------------------------------------------------------------
// ones_comp_checksum
// Accumulates a block of words with ones'-complement addition and presents
// the sum, its inverse (checksum) and the word count once the block ends.
// Optional build macro:
//   ONES_COMP_NEGZERO_NORM_EN - present an all-ones (negative zero) sum as
//                               out_sum=0 / out_chk=all-ones.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   / in_ready   input word handshake
//   in_data    [W-1:0]      input word
//   in_last                 final word of the block
//   out_valid  / out_ready  result handshake
//   out_sum    [W-1:0]      ones'-complement sum (0 when not holding)
//   out_chk    [W-1:0]      inverted sum (0 when not holding)
//   out_count  [CNT_W-1:0]  saturating count of accepted words
// ----------------------------------------------------------------------------
module ones_comp_checksum
  import ones_comp_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [W-1:0]     out_chk,
  output logic [CNT_W-1:0] out_count
);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_sum;
  logic [W-1:0]     res_sum;
  logic             hold;
  logic             in_fire;

  // A fresh block starts from zero, so the adder sees 0 in IDLE.
  assign add_a = (state_q == ST_IDLE) ? '0 : acc_q;

  oc_add_eac #(.W(W)) u_add (
    .a_i   (add_a),
    .b_i   (in_data),
    .sum_o (add_sum)
  );

  assign hold      = (state_q == ST_HOLD);
  assign in_ready  = ready_q && !hold;
  assign out_valid = hold;
  assign in_fire   = in_valid && in_ready;

  // Next-state logic: accumulate on each accepted word, hold the result
  // until it is taken, then clear back to IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (in_fire) begin
          acc_d = add_sum;
          if (state_q == ST_IDLE) begin
            count_d = CNT_W'(1);
          end else if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // ready_q keeps in_ready low through reset and until the first clock edge
  // after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

  // Result presentation, with optional negative-zero normalisation.
  always_comb begin
    res_sum = acc_q;
`ifdef ONES_COMP_NEGZERO_NORM_EN
    if (acc_q == {W{1'b1}}) begin
      res_sum = '0;
    end
`else
    res_sum = acc_q;
`endif
  end

  assign out_sum   = hold ? res_sum  : '0;
  assign out_chk   = hold ? ~res_sum : '0;
  assign out_count = hold ? count_q  : '0;

endmodule : ones_comp_checksum

// File: tb/tb_ones_comp_checksum.sv
// ----------------------------------------------------------------------------
// tb_ones_comp_checksum
// Directed bench for ones_comp_checksum with W=4, CNT_W=8.
// ----------------------------------------------------------------------------
module tb_ones_comp_checksum;

  localparam int W     = 4;
  localparam int CNT_W = 8;

`ifdef ONES_COMP_NEGZERO_NORM_EN
  localparam logic [W-1:0] NZ_SUM = 4'h0;
  localparam logic [W-1:0] NZ_CHK = 4'hF;
`else
  localparam logic [W-1:0] NZ_SUM = 4'hF;
  localparam logic [W-1:0] NZ_CHK = 4'h0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic [W-1:0]     out_chk;
  logic [CNT_W-1:0] out_count;

  int nCompared;
  int nMismatched;

  ones_comp_checksum #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_chk   (out_chk),
    .out_count (out_count)
  );

  // 10-unit clock; stimulus and sampling happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference of the end-around-carry addition.
  function automatic logic [W-1:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s > 15) s = s - 16 + 1;
    return W'(s);
  endfunction

  // Presents one word for exactly one rising edge; called at a falling edge.
  task automatic sendWord(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 4'h0 ||
        out_chk !== 4'h0 || out_count !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b sum=%h chk=%h cnt=%0d expected 0/0/0/0/0",
               in_ready, out_valid, out_sum, out_chk, out_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(negedge clk);
    nCompared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ready_after_edge: got rdy=%b vld=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_two_words;
    sendWord(4'h3, 1'b0);
    sendWord(4'h5, 1'b1);
    nCompared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL two_hold: got vld=%b rdy=%b expected 1/0", out_valid, in_ready);
    end
    nCompared++;
    if (out_sum !== 4'h8 || out_chk !== 4'h7 || out_count !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL two_result: got sum=%h chk=%h cnt=%0d expected 8/7/2", out_sum, out_chk, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'h0) begin
      nMismatched++;
      $display("[TB] FAIL two_release: got vld=%b rdy=%b sum=%h expected 0/1/0", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_carry;
    sendWord(4'hA, 1'b0);
    sendWord(4'h7, 1'b0);
    nCompared++;
    if (dut.acc_q !== 4'h2 || out_sum !== 4'h0 || out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL carry_mid: got acc=%h sum=%h vld=%b expected 2/0/0", dut.acc_q, out_sum, out_valid);
    end
    sendWord(4'hC, 1'b1);
    nCompared++;
    if (out_sum !== 4'hE || out_chk !== 4'h1 || out_count !== 8'd3) begin
      nMismatched++;
      $display("[TB] FAIL carry_result: got sum=%h chk=%h cnt=%0d expected e/1/3", out_sum, out_chk, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_negzero;
    sendWord(4'h7, 1'b0);
    sendWord(4'h8, 1'b1);
    nCompared++;
    if (out_sum !== NZ_SUM || out_chk !== NZ_CHK || out_count !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL negzero: got sum=%h chk=%h cnt=%0d expected %h/%h/2",
               out_sum, out_chk, out_count, NZ_SUM, NZ_CHK);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_hold;
    sendWord(4'h9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      nCompared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'h9 ||
          out_chk !== 4'h6 || out_count !== 8'd1) begin
        nMismatched++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b rdy=%b sum=%h chk=%h cnt=%0d expected 1/0/9/6/1",
                 i, out_valid, in_ready, out_sum, out_chk, out_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL hold_to_idle: got vld=%b rdy=%b cnt=%0d expected 0/1/0", out_valid, in_ready, out_count);
    end
  endtask

  task automatic test_mid_reset;
    sendWord(4'h4, 1'b0);
    sendWord(4'h6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 4'h0 ||
        out_chk !== 4'h0 || out_count !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b vld=%b sum=%h chk=%h cnt=%0d expected 0/0/0/0/0",
               in_ready, out_valid, out_sum, out_chk, out_count);
    end
    nCompared++;
    if (dut.acc_q !== 4'h0 || dut.count_q !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL midreset_state: got acc=%h cnt=%0d expected 0/0", dut.acc_q, dut.count_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendWord(4'h1, 1'b0);
    sendWord(4'h1, 1'b1);
    nCompared++;
    if (out_sum !== 4'h2 || out_chk !== 4'hD || out_count !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL midreset_newblock: got sum=%h chk=%h cnt=%0d expected 2/d/2", out_sum, out_chk, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_saturate;
    logic [W-1:0] model;
    model = 4'h0;
    for (int i = 0; i < 300; i++) begin
      model = refAdd(model, 4'h1);
      sendWord(4'h1, (i == 299));
    end
`ifdef ONES_COMP_NEGZERO_NORM_EN
    if (model == 4'hF) model = 4'h0;
`endif
    nCompared++;
    if (out_count !== 8'd255) begin
      nMismatched++;
      $display("[TB] FAIL sat_count: got %0d expected 255", out_count);
    end
    nCompared++;
    if (out_sum !== model || out_chk !== ~model) begin
      nMismatched++;
      $display("[TB] FAIL sat_sum: got sum=%h chk=%h expected %h/%h", out_sum, out_chk, model, ~model);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_two_words();
    test_carry();
    test_negzero();
    test_hold();
    test_mid_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_ones_comp_checksum
